// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan sequencer and its environment: host handshake,
// snapshot result, and the select/return path to the registered 4:1 mux stage.
interface mux_scan_ctrl_if;
    logic       start;
    logic       continuous;
    logic [1:0] sel;
    logic       q_in;
    logic       busy;
    logic       done;
    logic [3:0] snapshot;
    logic       change;

    // Environment side: host plus mux stage
    modport master (
        output start,
        output continuous,
        output q_in,
        input  sel,
        input  busy,
        input  done,
        input  snapshot,
        input  change
    );

    // Scan sequencer side
    modport slave (
        input  start,
        input  continuous,
        input  q_in,
        output sel,
        output busy,
        output done,
        output snapshot,
        output change
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer: steps the mux select through channels 0..3, samples the
// registered mux output per channel and publishes a 4-bit snapshot with done/change.
module mux_scan_ctrl #(
    parameter int         HOLD     = 2,
    parameter logic [3:0] CHG_INIT = 4'b0000
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.slave bus
);

    localparam int CW = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0]    state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    sel_r;
    logic [2:0]    shadow_r;
    logic          busy_r;
    logic          done_r;
    logic [3:0]    snap_r;
    logic          change_r;
    logic [3:0]    new_snap_s;

    function automatic logic snap_differs(input logic [3:0] a, input logic [3:0] b);
        return |(a ^ b);
    endfunction

    // Candidate snapshot formed on the edge that samples channel 3
    always_comb begin
        new_snap_s = {bus.q_in, shadow_r};
    end

    // Scan FSM, hold counter, shadow capture and snapshot publication
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            sel_r    <= 2'd0;
            shadow_r <= 3'b000;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            snap_r   <= CHG_INIT;
            change_r <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            change_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_r <= ST_SCAN;
                        sel_r   <= 2'd0;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_r <= {CW{1'b0}};
                        case (sel_r)
                            2'd0: begin
                                shadow_r[0] <= bus.q_in;
                                sel_r       <= 2'd1;
                            end
                            2'd1: begin
                                shadow_r[1] <= bus.q_in;
                                sel_r       <= 2'd2;
                            end
                            2'd2: begin
                                shadow_r[2] <= bus.q_in;
                                sel_r       <= 2'd3;
                            end
                            default: begin
                                // Channel 3 closes the scan; continuous is sampled here only
                                snap_r   <= new_snap_s;
                                done_r   <= 1'b1;
                                change_r <= snap_differs(new_snap_s, snap_r);
                                sel_r    <= 2'd0;
                                if (bus.continuous) begin
                                    state_r <= ST_SCAN;
                                    busy_r  <= 1'b1;
                                end else begin
                                    state_r <= ST_IDLE;
                                    busy_r  <= 1'b0;
                                end
                            end
                        endcase
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                    sel_r   <= 2'd0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel      = sel_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.snapshot = snap_r;
    assign bus.change   = change_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a registered 4:1 mux model and a
// scoreboard of expected {snapshot, change} results popped on each done pulse.
module tb_mux_scan_ctrl;

    logic clk;
    logic rst;
    logic [3:0] mux_in;

    mux_scan_ctrl_if bus ();

    mux_scan_ctrl #(.HOLD(2), .CHG_INIT(4'b0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    bit saw_done     = 1'b0;
    logic [3:0] model_snap = 4'b0000;
    logic [4:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered mux stage: output follows sel one cycle late
    always_ff @(posedge clk) begin
        bus.q_in <= mux_in[bus.sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_scan(input logic [3:0] v);
        sb.push_back({v, (v != model_snap)});
        model_snap = v;
    endtask

    task automatic tick();
        logic [4:0] e;
        @(posedge clk);
        #1;
        if (bus.done) begin
            done_cnt++;
            saw_done = 1'b1;
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("snapshot", 32'(bus.snapshot), 32'(e[4:1]));
                check("change", 32'(bus.change), 32'(e[0]));
            end
        end else begin
            check("change_without_done", 32'(bus.change), 32'd0);
        end
    endtask

    task automatic wait_done(input int budget);
        saw_done = 1'b0;
        for (int i = 0; i < budget && !saw_done; i++) tick();
        check("done_seen", 32'(saw_done), 32'd1);
    endtask

    task automatic start_scan(input logic [3:0] v);
        mux_in    = v;
        push_scan(v);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        saw_done  = 1'b0;
    endtask

    initial begin
        int d0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        mux_in         = 4'b0000;
        repeat (3) tick();
        rst = 1'b0;

        // 1: reset state, then idle with no start
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_snapshot", 32'(bus.snapshot), 32'd0);
        check("rst_change", 32'(bus.change), 32'd0);
        d0 = done_cnt;
        repeat (20) tick();
        check("idle_no_done", 32'(done_cnt), 32'(d0));
        check("idle_busy", 32'(bus.busy), 32'd0);

        // 2: single scan of 1010, select sequence and latency
        d0 = done_cnt;
        start_scan(4'b1010);
        for (int c = 1; c <= 8; c++) begin
            check("sel_seq", 32'(bus.sel), 32'((c - 1) / 2));
            check("busy_scan", 32'(bus.busy), 32'd1);
            if (c < 8) tick();
        end
        check("no_early_done", 32'(done_cnt), 32'(d0));
        tick();
        check("done_at_8", 32'(saw_done), 32'd1);
        check("busy_fall", 32'(bus.busy), 32'd0);
        check("sel_wrap", 32'(bus.sel), 32'd0);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("snapshot_hold", 32'(bus.snapshot), 32'hA);

        // 3: repeat same value (no change), then new value
        start_scan(4'b1010);
        wait_done(12);
        start_scan(4'b0110);
        wait_done(12);

        // 4: continuous back-to-back scans with alternating inputs
        bus.continuous = 1'b1;
        start_scan(4'b1111);
        for (int s = 0; s < 4; s++) begin
            d0 = done_cnt;
            repeat (8) tick();
            check("cont_done_period", 32'(done_cnt), 32'(d0 + 1));
            check("cont_done_now", 32'(bus.done), 32'd1);
            if (s < 3) begin
                mux_in = ~mux_in;
                push_scan(mux_in);
                check("cont_busy", 32'(bus.busy), 32'd1);
            end
            if (s == 2) bus.continuous = 1'b0;
        end
        check("cont_stop_busy", 32'(bus.busy), 32'd0);

        // 5: start pulses during a scan are ignored
        d0 = done_cnt;
        start_scan(4'b1001);
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (16) tick();
        check("ignored_start_one_done", 32'(done_cnt), 32'(d0 + 1));
        check("ignored_start_idle", 32'(bus.busy), 32'd0);
        start_scan(4'b1001);
        wait_done(12);

        // 6: reset in mid-scan discards the partial scan
        mux_in    = 4'b1111;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_sel", 32'(bus.sel), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_snapshot", 32'(bus.snapshot), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        rst        = 1'b0;
        model_snap = 4'b0000;
        d0 = done_cnt;
        repeat (20) tick();
        check("mid_rst_no_done", 32'(done_cnt), 32'(d0));

        // First scan after reset compares against the reset snapshot
        start_scan(4'b0000);
        wait_done(12);
        start_scan(4'b0001);
        wait_done(12);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
